// File: rtl/lab2_proc_proc_ctrl_hazard_if.sv
// Control bundle between the D-stage decoder/pipeline datapath and the hazard unit.
// The decoder side uses the master modport and the hazard unit uses the slave modport.
interface lab2_proc_proc_ctrl_hazard_if;
  logic       val_D;
  logic       rs1_en_D;
  logic       rs2_en_D;
  logic [4:0] rs1_D;
  logic [4:0] rs2_D;
  logic       rf_wen_D;
  logic [4:0] rf_waddr_D;
  logic       is_load_D;
  logic       jump_D;
  logic       brj_taken_X;
  logic       ostall_M;

  logic       reg_en_F;
  logic       reg_en_D;
  logic       reg_en_X;
  logic       reg_en_M;
  logic       squash_F;
  logic       squash_D;
  logic       stall_D;
  logic [1:0] op1_byp_sel_D;
  logic [1:0] op2_byp_sel_D;
  logic       val_X;
  logic       val_M;
  logic       val_W;

  modport master (
    output val_D, rs1_en_D, rs2_en_D, rs1_D, rs2_D, rf_wen_D, rf_waddr_D,
           is_load_D, jump_D, brj_taken_X, ostall_M,
    input  reg_en_F, reg_en_D, reg_en_X, reg_en_M, squash_F, squash_D,
           stall_D, op1_byp_sel_D, op2_byp_sel_D, val_X, val_M, val_W
  );

  modport slave (
    input  val_D, rs1_en_D, rs2_en_D, rs1_D, rs2_D, rf_wen_D, rf_waddr_D,
           is_load_D, jump_D, brj_taken_X, ostall_M,
    output reg_en_F, reg_en_D, reg_en_X, reg_en_M, squash_F, squash_D,
           stall_D, op1_byp_sel_D, op2_byp_sel_D, val_X, val_M, val_W
  );
endinterface

// File: rtl/lab2_proc_proc_ctrl_hazard.sv
// Hazard controller for the F/D/X/M/W pipeline: writer scoreboard, stalls, squashes, bypass selects.
// Define LAB2_PROC_BYPASS_EN for full bypassing; otherwise any pending writer stalls D.
module lab2_proc_proc_ctrl_hazard (
  input logic                          clk,
  input logic                          reset,
  lab2_proc_proc_ctrl_hazard_if.slave  hz
);

  logic       sb_val_X;
  logic       sb_wen_X;
  logic [4:0] sb_waddr_X;
  logic       sb_load_X;
  logic       sb_val_M;
  logic       sb_wen_M;
  logic [4:0] sb_waddr_M;
  logic       sb_val_W;
  logic       sb_wen_W;
  logic [4:0] sb_waddr_W;

  logic m1_x, m1_m, m1_w;
  logic m2_x, m2_m, m2_w;
  logic stall_m;
  logic load_use;
  logic hazard;
  logic brj_q;
  logic stall_d;
  logic squash_d;
  logic jump_q;
  logic adv_d;

  function automatic logic match(input logic       en,
                                 input logic [4:0] rs,
                                 input logic       v,
                                 input logic       wen,
                                 input logic [4:0] waddr);
    return en && (rs != 5'd0) && v && wen && (waddr == rs);
  endfunction

`ifdef LAB2_PROC_BYPASS_EN
  function automatic logic [1:0] byp_sel(input logic mx, input logic mm, input logic mw);
    if (mx)      return 2'd1;
    else if (mm) return 2'd2;
    else if (mw) return 2'd3;
    else         return 2'd0;
  endfunction
`endif

  // A branch squash discards the D instruction, so it also cancels any hazard stall it would have caused.
  always_comb begin
    m1_x = match(hz.rs1_en_D, hz.rs1_D, sb_val_X, sb_wen_X, sb_waddr_X);
    m1_m = match(hz.rs1_en_D, hz.rs1_D, sb_val_M, sb_wen_M, sb_waddr_M);
    m1_w = match(hz.rs1_en_D, hz.rs1_D, sb_val_W, sb_wen_W, sb_waddr_W);
    m2_x = match(hz.rs2_en_D, hz.rs2_D, sb_val_X, sb_wen_X, sb_waddr_X);
    m2_m = match(hz.rs2_en_D, hz.rs2_D, sb_val_M, sb_wen_M, sb_waddr_M);
    m2_w = match(hz.rs2_en_D, hz.rs2_D, sb_val_W, sb_wen_W, sb_waddr_W);

    stall_m  = hz.ostall_M && sb_val_M;
    brj_q    = hz.brj_taken_X && sb_val_X && !stall_m;
    load_use = (m1_x || m2_x) && sb_load_X;
`ifdef LAB2_PROC_BYPASS_EN
    hazard   = load_use;
`else
    hazard   = load_use || m1_x || m2_x || m1_m || m2_m || m1_w || m2_w;
`endif
    stall_d  = hz.val_D && ((hazard && !brj_q) || stall_m);
    squash_d = brj_q;
    jump_q   = hz.jump_D && hz.val_D && !stall_d && !squash_d;
    adv_d    = hz.val_D && !stall_d && !squash_d;
  end

  assign hz.stall_D  = stall_d;
  assign hz.squash_D = squash_d;
  assign hz.squash_F = squash_d || jump_q;
  assign hz.reg_en_F = !stall_d && !stall_m;
  assign hz.reg_en_D = !stall_d && !stall_m;
  assign hz.reg_en_X = !stall_m;
  assign hz.reg_en_M = !stall_m;
  assign hz.val_X    = sb_val_X;
  assign hz.val_M    = sb_val_M;
  assign hz.val_W    = sb_val_W;

`ifdef LAB2_PROC_BYPASS_EN
  assign hz.op1_byp_sel_D = byp_sel(m1_x, m1_m, m1_w);
  assign hz.op2_byp_sel_D = byp_sel(m2_x, m2_m, m2_w);
`else
  assign hz.op1_byp_sel_D = 2'd0;
  assign hz.op2_byp_sel_D = 2'd0;
`endif

  // A memory stall freezes X and M in place and drains W with a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_val_X   <= 1'b0;
      sb_wen_X   <= 1'b0;
      sb_waddr_X <= 5'd0;
      sb_load_X  <= 1'b0;
      sb_val_M   <= 1'b0;
      sb_wen_M   <= 1'b0;
      sb_waddr_M <= 5'd0;
      sb_val_W   <= 1'b0;
      sb_wen_W   <= 1'b0;
      sb_waddr_W <= 5'd0;
    end else if (stall_m) begin
      sb_val_W   <= 1'b0;
      sb_wen_W   <= 1'b0;
    end else begin
      sb_val_X   <= adv_d;
      sb_wen_X   <= adv_d && hz.rf_wen_D;
      sb_waddr_X <= hz.rf_waddr_D;
      sb_load_X  <= adv_d && hz.is_load_D;
      sb_val_M   <= sb_val_X;
      sb_wen_M   <= sb_wen_X;
      sb_waddr_M <= sb_waddr_X;
      sb_val_W   <= sb_val_M;
      sb_wen_W   <= sb_wen_M;
      sb_waddr_W <= sb_waddr_M;
    end
  end

endmodule

// File: tb/tb_lab2_proc_proc_ctrl_hazard.sv
// Directed scoreboard bench for the hazard controller; expectations cover both
// settings of LAB2_PROC_BYPASS_EN.
module tb_lab2_proc_proc_ctrl_hazard;

`ifdef LAB2_PROC_BYPASS_EN
  localparam bit B = 1'b1;
`else
  localparam bit B = 1'b0;
`endif

  typedef struct {
    logic       reset;
    logic       val;
    logic       rs1_en;
    logic [4:0] rs1;
    logic       rs2_en;
    logic [4:0] rs2;
    logic       wen;
    logic [4:0] waddr;
    logic       load;
    logic       jump;
    logic       brj;
    logic       ostall;
  } stim_t;

  typedef struct {
    string       name;
    logic [13:0] vec;
    logic        chk_byp;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  lab2_proc_proc_ctrl_hazard_if hz_if ();

  lab2_proc_proc_ctrl_hazard dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s = '{reset: 1'b0, val: 1'b0, rs1_en: 1'b0, rs1: 5'd0, rs2_en: 1'b0, rs2: 5'd0,
          wen: 1'b0, waddr: 5'd0, load: 1'b0, jump: 1'b0, brj: 1'b0, ostall: 1'b0};
    return s;
  endfunction

  function automatic stim_t instr(input logic r1en, input logic [4:0] r1,
                                  input logic r2en, input logic [4:0] r2,
                                  input logic w, input logic [4:0] wa, input logic ld);
    stim_t s;
    s = idle();
    s.val = 1'b1;  s.rs1_en = r1en; s.rs1 = r1; s.rs2_en = r2en; s.rs2 = r2;
    s.wen = w;     s.waddr = wa;    s.load = ld;
    return s;
  endfunction

  function automatic stim_t rnd_reset();
    stim_t s;
    s = idle();
    s.reset  = 1'b1;
    s.val    = 1'($urandom);
    s.rs1_en = 1'($urandom);
    s.rs1    = 5'($urandom);
    s.rs2_en = 1'($urandom);
    s.rs2    = 5'($urandom);
    s.wen    = 1'($urandom);
    s.waddr  = 5'($urandom);
    s.load   = 1'($urandom);
    s.brj    = 1'($urandom);
    s.ostall = 1'($urandom);
    return s;
  endfunction

  // Expected vector order: {reg_en_F,D,X,M, squash_F,D, stall_D, val_X,M,W, op1_sel, op2_sel}
  function automatic exp_t ex(input string nm, input logic stall, input logic sqf, input logic sqd,
                              input logic en_fd, input logic en_xm,
                              input logic vx, input logic vm, input logic vw,
                              input logic [1:0] b1, input logic [1:0] b2, input logic chk);
    exp_t e;
    e.name    = nm;
    e.vec     = {en_fd, en_fd, en_xm, en_xm, sqf, sqd, stall, vx, vm, vw, b1, b2};
    e.chk_byp = chk;
    return e;
  endfunction

  function automatic exp_t quiet(input string nm, input logic vx, input logic vm, input logic vw);
    return ex(nm, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, vx, vm, vw, 2'd0, 2'd0, 1'b1);
  endfunction

  task automatic drive(input stim_t s);
    reset               = s.reset;
    hz_if.val_D         = s.val;
    hz_if.rs1_en_D      = s.rs1_en;
    hz_if.rs1_D         = s.rs1;
    hz_if.rs2_en_D      = s.rs2_en;
    hz_if.rs2_D         = s.rs2;
    hz_if.rf_wen_D      = s.wen;
    hz_if.rf_waddr_D    = s.waddr;
    hz_if.is_load_D     = s.load;
    hz_if.jump_D        = s.jump;
    hz_if.brj_taken_X   = s.brj;
    hz_if.ostall_M      = s.ostall;
  endtask

  task automatic applyStimulus(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    drive(s);
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [13:0] act;
    logic [13:0] mask;
    act  = {hz_if.reg_en_F, hz_if.reg_en_D, hz_if.reg_en_X, hz_if.reg_en_M,
            hz_if.squash_F, hz_if.squash_D, hz_if.stall_D,
            hz_if.val_X, hz_if.val_M, hz_if.val_W,
            hz_if.op1_byp_sel_D, hz_if.op2_byp_sel_D};
    mask = e.chk_byp ? 14'h3fff : 14'h3ff0;
    checks++;
    if ((act & mask) !== (e.vec & mask)) begin
      errors++;
      $display("[TB] FAIL %s: got %b required %b (mask %b)", e.name, act, e.vec, mask);
    end
  endtask

  // Monitor: outputs are presented every cycle, checked mid-cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    stim_t s;
    checks = 0;
    errors = 0;
    drive(rnd_reset());

    applyStimulus(rnd_reset(), quiet("reset_0", 0, 0, 0));
    applyStimulus(rnd_reset(), quiet("reset_1", 0, 0, 0));

    // ALU-to-ALU dependence on x5: bypass from X, M, W or three stalls without bypass.
    applyStimulus(instr(1, 0, 0, 0, 1, 5, 0), quiet("addi_x5", 0, 0, 0));
    s = instr(1, 5, 1, 5, 1, 6, 0);
    applyStimulus(s, ex("alu_dep_x", !B, 0, 0, B, 1, 1, 0, 0, B ? 2'd1 : 2'd0, B ? 2'd1 : 2'd0, B));
    applyStimulus(s, ex("alu_dep_m", !B, 0, 0, B, 1, B, 1, 0, B ? 2'd2 : 2'd0, B ? 2'd2 : 2'd0, B));
    applyStimulus(s, ex("alu_dep_w", !B, 0, 0, B, 1, B, B, 1, B ? 2'd3 : 2'd0, B ? 2'd3 : 2'd0, B));
    applyStimulus(s, quiet("alu_dep_clear", B, B, B));
    s = idle(); s.reset = 1'b1;
    applyStimulus(s, quiet("flush_a", 1, B, B));
    applyStimulus(idle(), quiet("empty_a", 0, 0, 0));

    // Load-use on x3.
    applyStimulus(instr(1, 1, 0, 0, 1, 3, 1), quiet("lw_x3", 0, 0, 0));
    s = instr(1, 3, 0, 0, 1, 4, 0);
    applyStimulus(s, ex("load_use", 1, 0, 0, 0, 1, 1, 0, 0, 2'd0, 2'd0, 0));
    applyStimulus(s, ex("load_use_m", !B, 0, 0, B, 1, 0, 1, 0, B ? 2'd2 : 2'd0, 2'd0, B));
    applyStimulus(s, ex("load_use_w", !B, 0, 0, B, 1, B, 0, 1, B ? 2'd3 : 2'd0, 2'd0, B));
    applyStimulus(s, quiet("load_use_clear", B, B, 0));
    s = idle(); s.reset = 1'b1;
    applyStimulus(s, quiet("flush_b", 1, B, B));
    applyStimulus(idle(), quiet("empty_b", 0, 0, 0));

    // A load targeting x0 never creates a dependence.
    applyStimulus(instr(1, 0, 0, 0, 1, 0, 1), quiet("lw_x0", 0, 0, 0));
    applyStimulus(instr(1, 0, 1, 0, 0, 0, 0), quiet("read_x0", 1, 0, 0));
    s = idle(); s.reset = 1'b1;
    applyStimulus(s, quiet("flush_c", 1, 1, 0));
    applyStimulus(idle(), quiet("empty_c", 0, 0, 0));

    // Taken branch over a pending load-use, then JAL.
    applyStimulus(instr(1, 1, 0, 0, 1, 3, 1), quiet("lw_x3_b", 0, 0, 0));
    s = instr(1, 3, 0, 0, 1, 4, 0); s.brj = 1'b1;
    applyStimulus(s, ex("brj_over_ld", 0, 1, 1, 1, 1, 1, 0, 0, B ? 2'd1 : 2'd0, 2'd0, 1));
    applyStimulus(idle(), quiet("brj_bubble", 0, 1, 0));
    s = instr(0, 0, 0, 0, 1, 1, 0); s.jump = 1'b1;
    applyStimulus(s, ex("jal", 0, 1, 0, 1, 1, 0, 0, 1, 2'd0, 2'd0, 1));
    s = idle(); s.reset = 1'b1;
    applyStimulus(s, quiet("flush_d", 1, 0, 0));
    applyStimulus(idle(), quiet("empty_d", 0, 0, 0));

    // Memory stall while a taken branch waits in X.
    applyStimulus(instr(0, 0, 0, 0, 1, 9, 0), quiet("addi_x9", 0, 0, 0));
    applyStimulus(instr(1, 2, 1, 0, 0, 0, 0), quiet("beq_d", 1, 0, 0));
    s = instr(1, 9, 0, 0, 1, 10, 0); s.brj = 1'b1; s.ostall = 1'b1;
    for (int i = 0; i < 3; i++)
      applyStimulus(s, ex("mem_stall", 1, 0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 0));
    s.ostall = 1'b0;
    applyStimulus(s, ex("mem_stall_release", 0, 1, 1, 1, 1, 1, 1, 0, B ? 2'd2 : 2'd0, 2'd0, 1));
    applyStimulus(idle(), quiet("after_squash", 0, 1, 1));

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending entries required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lab2_proc_proc_ctrl_hazard.md
# lab2_proc_proc_ctrl_hazard

Pipeline hazard controller for the five-stage (F/D/X/M/W) processor. It tracks in-flight register writers in X, M and W and computes per-stage register enables, stall and squash signals, and D-stage operand bypass selects. It sits in the control unit beside the decoder that drives the immediate generator. It consumes decoded D-stage fields, X-stage branch resolution and an M-stage memory stall.

## Interface
- No parameters.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- val_D  in  1  D holds a valid instruction
- rs1_en_D, rs2_en_D  in  1 each  instruction reads rs1/rs2
- rs1_D, rs2_D  in  5 each  source register addresses
- rf_wen_D  in  1  instruction writes rd
- rf_waddr_D  in  5  rd address
- is_load_D  in  1  instruction is LW
- jump_D  in  1  JAL in D (target known in D)
- brj_taken_X  in  1  taken branch or JALR resolved in X
- ostall_M  in  1  data memory not ready; M cannot advance
- reg_en_F, reg_en_D, reg_en_X, reg_en_M  out  1 each  pipeline register enables
- squash_F, squash_D  out  1 each  insert bubble into next stage
- stall_D  out  1  D held this cycle
- op1_byp_sel_D, op2_byp_sel_D  out  2 each  0 = RF, 1 = X, 2 = M, 3 = W
- val_X, val_M, val_W  out  1 each  scoreboard valid bits (debug/trace)

## Operation
- Scoreboard: per stage S in {X, M, W}, holds val_S, wen_S, waddr_S[4:0] and load_S (X only).
- Match rule:
  - match_S(rs) = rs_en_D && rs != 0 && val_S && wen_S && waddr_S == rs.
  - x0 never matches.
- Load-use: any match against X with load_X asserts stall_D.
- stall_M = ostall_M && val_M.
  - Freezes F, D, X and M: reg_en_F/D/X/M = 0.
  - W receives a bubble.
- stall_D = val_D && (hazard stall || stall_M).
  - reg_en_F = reg_en_D = !stall_D.
  - A hazard stall with no stall_M inserts a bubble into X (val_X' = 0) while M and W advance.
- brj_taken_X is qualified by val_X && !stall_M. When qualified:
  - squash_F = squash_D = 1.
  - The D instruction does not enter X (bubble).
  - Squash overrides stall_D for D-register update: reg_en_D = 1, reg_en_F = 1.
- jump_D is qualified by val_D && !stall_D && !squash_D. When qualified: squash_F = 1.
- Bypass select priority: X > M > W > RF. Selects are computed combinationally every cycle and are don't-care when stall_D = 1.
- Scoreboard update at posedge when not stalled:
  - X ← D fields, gated by val_D && !stall_D && !squash_D.
  - M ← X.
  - W ← M (or a bubble when stall_M).

## Timing
- All outputs are combinational from the scoreboard state and the current inputs.
- Scoreboard updates on posedge clk.
- Reset (synchronous): val_X/M/W = 0, wen_* = 0, load_X = 0. Consequently all stalls and squashes are 0, all reg_en = 1, and byp_sel = 0 unless inputs request otherwise.
- Reset mid-operation flushes all in-flight writers in one cycle. The next cycle sees an empty scoreboard.
- Load-use costs exactly 1 bubble. ALU-to-ALU with bypass costs 0.
- Taken branch costs 2 bubbles. JAL costs 1.
- Simultaneous brj_taken_X and load-use stall: the squash wins and no stall is recorded, because the D instruction is discarded.
- Simultaneous ostall_M and brj_taken_X: the squash is deferred until stall_M drops. X holds, so brj_taken_X is re-presented.
- RF writes occur at end of W. A D read in the same cycle requires the W bypass.

## Configuration
- LAB2_PROC_BYPASS_EN defined: full bypassing as above. Only load-use stalls D.
- LAB2_PROC_BYPASS_EN undefined:
  - byp_sel outputs are tied to 0.
  - Any match against X, M or W asserts stall_D.
  - A dependent instruction waits until its writer leaves W: 3 bubbles when back-to-back.

## Test plan
- Reset asserted for 2 cycles with random inputs. Required: val_X/M/W = 0, stall_D = 0, squash_* = 0, all reg_en = 1.
- ADDI x5 followed by ADD x6,x5,x5 (bypass on). Required: op1/op2_byp_sel_D = 1 with no stall. With writer in M, select = 2. With writer in W, select = 3.
- LW x3 followed by ADDI x4,x3. Required: stall_D = 1 for exactly 1 cycle, val_X = 0 the next cycle, then byp_sel = 2. With bypass off: 3 stall cycles, byp_sel = 0.
- Write to x0 in X followed by a read of x0. Required: no stall, byp_sel = 0.
- brj_taken_X = 1 while a load-use stall is pending in D. Required: squash_F = squash_D = 1, stall_D = 0, val_X = 0 next cycle. jump_D alone: squash_F = 1 only.
- ostall_M = 1 for 3 cycles with val_M = 1 and brj_taken_X = 1. Required: reg_en_F/D/X/M = 0 and squash_* = 0 throughout, val_W = 0 bubbles. Squash fires in the cycle ostall_M drops.
